// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master simple-bus arbiter.
package bus_arb_pkg;

    localparam int BUS_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/bus_arb_port.sv
// Per-master front end: request latch, read-data holding register and ready.
module bus_arb_port
    import bus_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_i,
    input  logic             we_i,
    input  logic             clr_i,
    input  logic             cap_i,
    input  logic [BUS_W-1:0] cap_data_i,
    output logic             req_o,
    output logic             kind_o,
    output logic [BUS_W-1:0] spo_o,
    output logic             ready_o
);

    logic             pend_q;
    logic             kind_q;
    logic [BUS_W-1:0] spo_q;
    logic             req_pulse;

    assign req_pulse = rd_i | we_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            kind_q <= 1'b0;
            spo_q  <= '0;
        end else begin
            // A pulse while already pending is a protocol violation and is dropped.
            if (clr_i) begin
                pend_q <= 1'b0;
            end else if (req_pulse && !pend_q) begin
                pend_q <= 1'b1;
                kind_q <= we_i;
            end
            if (cap_i) begin
                spo_q <= cap_data_i;
            end
        end
    end

    // The live pulse is visible to the arbiter in its own cycle, so IDLE can grant without waiting for the latch.
    assign req_o   = pend_q | req_pulse;
    assign kind_o  = pend_q ? kind_q : we_i;
    assign spo_o   = spo_q;
    assign ready_o = ~req_pulse & ~pend_q;

endmodule

// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter serialising rd/we pulses onto one slave port.
module bus_arb2
    import bus_arb_pkg::*;
#(
    parameter int               TIMEOUT_CYCLES = 0,
    parameter logic [BUS_W-1:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BUS_W-1:0] m0_a,
    input  logic [BUS_W-1:0] m0_d,
    input  logic             m0_we,
    input  logic             m0_rd,
    output logic [BUS_W-1:0] m0_spo,
    output logic             m0_ready,
    input  logic [BUS_W-1:0] m1_a,
    input  logic [BUS_W-1:0] m1_d,
    input  logic             m1_we,
    input  logic             m1_rd,
    output logic [BUS_W-1:0] m1_spo,
    output logic             m1_ready,
    output logic [BUS_W-1:0] s_a,
    output logic [BUS_W-1:0] s_d,
    output logic             s_we,
    output logic             s_rd,
    input  logic [BUS_W-1:0] s_spo,
    input  logic             s_ready
);

    state_e           state_q;
    logic             last_grant_q;
    logic             s_rd_q;
    logic             s_we_q;
    logic [31:0]      cnt_q;

    logic             req0, req1, kind0, kind1;
    logic             grant_d, kind_d;
    logic             timeout_hit, done;
    logic [BUS_W-1:0] cap_data;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant_d = req1;
        if (req0 && req1) begin
            grant_d = ~last_grant_q;
        end
        kind_d = grant_d ? kind1 : kind0;
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign done        = (state_q == ST_WAIT) && (s_ready || timeout_hit);
    assign cap_data    = s_ready ? s_spo : TIMEOUT_DATA;

    bus_arb_port u_port0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_i       (m0_rd),
        .we_i       (m0_we),
        .clr_i      (done & ~last_grant_q),
        .cap_i      (done & ~last_grant_q),
        .cap_data_i (cap_data),
        .req_o      (req0),
        .kind_o     (kind0),
        .spo_o      (m0_spo),
        .ready_o    (m0_ready)
    );

    bus_arb_port u_port1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_i       (m1_rd),
        .we_i       (m1_we),
        .clr_i      (done & last_grant_q),
        .cap_i      (done & last_grant_q),
        .cap_data_i (cap_data),
        .req_o      (req1),
        .kind_o     (kind1),
        .spo_o      (m1_spo),
        .ready_o    (m1_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            s_rd_q       <= 1'b0;
            s_we_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s_rd_q <= 1'b0;
            s_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Holding off while s_ready=0 lets a slave busy from before a reset finish first.
                    if ((req0 || req1) && s_ready) begin
                        last_grant_q <= grant_d;
                        s_rd_q       <= ~kind_d;
                        s_we_q       <= kind_d;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_rd = s_rd_q;
    assign s_we = s_we_q;
    assign s_a  = last_grant_q ? m1_a : m0_a;
    assign s_d  = last_grant_q ? m1_d : m0_d;

endmodule

// File: tb/tb_bus_arb2.sv
// Directed, cycle-by-cycle checks of bus_arb2 with an 8-cycle slave timeout.
module tb_bus_arb2;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_a, m0_d, m1_a, m1_d, m0_spo, m1_spo;
    logic        m0_we, m0_rd, m0_ready, m1_we, m1_rd, m1_ready;
    logic [31:0] s_a, s_d, s_spo;
    logic        s_we, s_rd, s_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int rd_base  = 0;

    bus_arb2 #(.TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_a     (m0_a),
        .m0_d     (m0_d),
        .m0_we    (m0_we),
        .m0_rd    (m0_rd),
        .m0_spo   (m0_spo),
        .m0_ready (m0_ready),
        .m1_a     (m1_a),
        .m1_d     (m1_d),
        .m1_we    (m1_we),
        .m1_rd    (m1_rd),
        .m1_spo   (m1_spo),
        .m1_ready (m1_ready),
        .s_a      (s_a),
        .s_d      (s_d),
        .s_we     (s_we),
        .s_rd     (s_rd),
        .s_spo    (s_spo),
        .s_ready  (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with s_rd high, sampled mid-cycle.
    always @(negedge clk) begin
        if (s_rd === 1'b1) rd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_a = '0; m0_d = '0; m0_we = 1'b0; m0_rd = 1'b0;
        m1_a = '0; m1_d = '0; m1_we = 1'b0; m1_rd = 1'b0;
        s_spo = '0; s_ready = 1'b1;
        #3;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        #2;
        check("rst_s_rd", {31'd0, s_rd}, 32'd0);
        check("rst_s_we", {31'd0, s_we}, 32'd0);
        check("rst_m0_ready", {31'd0, m0_ready}, 32'd1);
        check("rst_m1_ready", {31'd0, m1_ready}, 32'd1);
        check("rst_m0_spo", m0_spo, 32'd0);
        check("rst_m1_spo", m1_spo, 32'd0);

        // Single m0 read, slave ready two cycles after s_rd
        rd_base = rd_cnt;
        cyc(); m0_a = 32'h1000; m0_rd = 1'b1; #2;
        check("t1_m0_ready_req", {31'd0, m0_ready}, 32'd0);
        check("t1_m1_ready_req", {31'd0, m1_ready}, 32'd1);
        check("t1_s_rd_c0", {31'd0, s_rd}, 32'd0);
        cyc(); m0_rd = 1'b0; s_ready = 1'b0; #2;
        check("t1_s_rd_issue", {31'd0, s_rd}, 32'd1);
        check("t1_s_we_issue", {31'd0, s_we}, 32'd0);
        check("t1_s_a", s_a, 32'h1000);
        check("t1_m0_ready_issue", {31'd0, m0_ready}, 32'd0);
        cyc(); #2;
        check("t1_s_rd_wait", {31'd0, s_rd}, 32'd0);
        cyc(); s_ready = 1'b1; s_spo = 32'h12345678; #2;
        check("t1_m0_ready_wait", {31'd0, m0_ready}, 32'd0);
        cyc(); #2;
        check("t1_m0_ready_done", {31'd0, m0_ready}, 32'd1);
        check("t1_m0_spo", m0_spo, 32'h12345678);
        check("t1_m1_ready_done", {31'd0, m1_ready}, 32'd1);
        cyc(); cyc(); #2;
        check("t1_rd_count", 32'(rd_cnt - rd_base), 32'd1);

        // Simultaneous m0 write / m1 read from reset: m0 first
        do_reset();
        m0_we = 1'b1; m0_a = 32'h2000; m0_d = 32'hA5A50001;
        m1_rd = 1'b1; m1_a = 32'h3000; #2;
        check("t2_both_ready_low", {30'd0, m0_ready, m1_ready}, 32'd0);
        cyc(); m0_we = 1'b0; m1_rd = 1'b0; s_spo = 32'h11111111; #2;
        check("t2_s_we_m0", {31'd0, s_we}, 32'd1);
        check("t2_s_rd_m0", {31'd0, s_rd}, 32'd0);
        check("t2_s_a_m0", s_a, 32'h2000);
        check("t2_s_d_m0", s_d, 32'hA5A50001);
        cyc(); #2;
        check("t2_s_we_wait", {31'd0, s_we}, 32'd0);
        cyc(); #2;
        check("t2_m0_ready", {31'd0, m0_ready}, 32'd1);
        check("t2_m0_spo_wr", m0_spo, 32'h11111111);
        check("t2_m1_ready_pend", {31'd0, m1_ready}, 32'd0);
        check("t2_s_rd_idle", {31'd0, s_rd}, 32'd0);
        cyc(); s_spo = 32'h22222222; #2;
        check("t2_s_rd_m1", {31'd0, s_rd}, 32'd1);
        check("t2_s_a_m1", s_a, 32'h3000);
        cyc(); cyc(); #2;
        check("t2_m1_ready", {31'd0, m1_ready}, 32'd1);
        check("t2_m1_spo", m1_spo, 32'h22222222);

        // Second m0 pulse while pending is ignored
        rd_base = rd_cnt;
        cyc(); m0_rd = 1'b1; m0_a = 32'h6000; #2;
        cyc(); m0_rd = 1'b0; s_ready = 1'b0; #2;
        check("t6_s_rd_issue", {31'd0, s_rd}, 32'd1);
        cyc(); m0_rd = 1'b1; #2;
        check("t6_m0_ready_dup", {31'd0, m0_ready}, 32'd0);
        cyc(); m0_rd = 1'b0; s_ready = 1'b1; s_spo = 32'h00000066; #2;
        cyc(); #2;
        check("t6_m0_ready", {31'd0, m0_ready}, 32'd1);
        check("t6_m0_spo", m0_spo, 32'h00000066);
        cyc(); cyc(); cyc(); #2;
        check("t6_rd_count", 32'(rd_cnt - rd_base), 32'd1);

        // Tie after an m0 grant: m1 wins this time
        cyc(); m0_rd = 1'b1; m0_a = 32'h7000; m1_rd = 1'b1; m1_a = 32'h7100; #2;
        cyc(); m0_rd = 1'b0; m1_rd = 1'b0; s_spo = 32'h00000071; #2;
        check("rr_s_rd_first", {31'd0, s_rd}, 32'd1);
        check("rr_s_a_first", s_a, 32'h7100);
        cyc(); cyc(); s_spo = 32'h00000070; #2;
        check("rr_m1_ready", {31'd0, m1_ready}, 32'd1);
        check("rr_m1_spo", m1_spo, 32'h00000071);
        check("rr_m0_ready_pend", {31'd0, m0_ready}, 32'd0);
        cyc(); #2;
        check("rr_s_a_second", s_a, 32'h7000);
        check("rr_s_rd_second", {31'd0, s_rd}, 32'd1);
        cyc(); cyc(); #2;
        check("rr_m0_spo", m0_spo, 32'h00000070);

        // m1 request arriving while m0 is in WAIT
        cyc(); m0_rd = 1'b1; m0_a = 32'h8000; #2;
        cyc(); m0_rd = 1'b0; s_ready = 1'b0; #2;
        cyc(); m1_rd = 1'b1; m1_a = 32'h8100; #2;
        check("t3_m1_ready_latched", {31'd0, m1_ready}, 32'd0);
        cyc(); m1_rd = 1'b0; s_ready = 1'b1; s_spo = 32'h00000080; #2;
        check("t3_s_rd_blocked", {31'd0, s_rd}, 32'd0);
        cyc(); s_spo = 32'h00000081; #2;
        check("t3_m0_spo", m0_spo, 32'h00000080);
        check("t3_m1_ready_pend", {31'd0, m1_ready}, 32'd0);
        check("t3_s_rd_idle", {31'd0, s_rd}, 32'd0);
        cyc(); #2;
        check("t3_s_rd_m1", {31'd0, s_rd}, 32'd1);
        check("t3_s_a_m1", s_a, 32'h8100);
        cyc(); cyc(); #2;
        check("t3_m1_spo", m1_spo, 32'h00000081);
        check("t3_m1_ready", {31'd0, m1_ready}, 32'd1);

        // Timeout after 8 WAIT cycles with a hung slave
        cyc(); m0_rd = 1'b1; m0_a = 32'h9000; #2;
        cyc(); m0_rd = 1'b0; s_ready = 1'b0; #2;
        for (int i = 0; i < 8; i++) cyc();
        #2;
        check("t4_m0_ready_early", {31'd0, m0_ready}, 32'd0);
        cyc(); s_ready = 1'b1; m1_rd = 1'b1; m1_a = 32'h9100; s_spo = 32'h00000091; #2;
        check("t4_m0_ready", {31'd0, m0_ready}, 32'd1);
        check("t4_m0_spo", m0_spo, 32'hDEADBEEF);
        cyc(); m1_rd = 1'b0; #2;
        check("t4_s_rd_m1", {31'd0, s_rd}, 32'd1);
        check("t4_s_a_m1", s_a, 32'h9100);
        cyc(); cyc(); #2;
        check("t4_m1_spo", m1_spo, 32'h00000091);
        check("t4_m1_ready", {31'd0, m1_ready}, 32'd1);

        // Reset pulsed mid-WAIT with the slave still busy
        cyc(); m0_rd = 1'b1; m0_a = 32'hA000; #2;
        cyc(); m0_rd = 1'b0; s_ready = 1'b0; #2;
        cyc(); #2;
        rst_n = 1'b0; #1;
        check("t5_s_rd_rst", {31'd0, s_rd}, 32'd0);
        check("t5_s_we_rst", {31'd0, s_we}, 32'd0);
        check("t5_readies_rst", {30'd0, m0_ready, m1_ready}, 32'd3);
        check("t5_m0_spo_rst", m0_spo, 32'd0);
        #1; rst_n = 1'b1;
        rd_base = rd_cnt;
        cyc(); m1_rd = 1'b1; m1_a = 32'hA100; #2;
        check("t5_m1_ready_req", {31'd0, m1_ready}, 32'd0);
        cyc(); m1_rd = 1'b0; #2;
        check("t5_s_rd_held1", {31'd0, s_rd}, 32'd0);
        cyc(); s_ready = 1'b1; #2;
        check("t5_s_rd_held2", {31'd0, s_rd}, 32'd0);
        cyc(); s_spo = 32'h000000A1; #2;
        check("t5_s_rd_issue", {31'd0, s_rd}, 32'd1);
        check("t5_s_a", s_a, 32'hA100);
        cyc(); cyc(); #2;
        check("t5_m1_spo", m1_spo, 32'h000000A1);
        check("t5_m1_ready", {31'd0, m1_ready}, 32'd1);
        cyc(); cyc(); #2;
        check("t5_rd_count", 32'(rd_cnt - rd_base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
